sb8_stream_fifo: RTL

- Leaf-level streaming buffer instantiated under each sb7 hierarchy node, directly downstream of the sb7 block.
- Accepts words from the parent stage over a valid/ready handshake and buffers up to DEPTH entries.
- Presents the buffered words first-word-fall-through to the next consumer.
- Reports occupancy and a peak-occupancy watermark for debug.

---
 rtl/sb8_stream_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/sb8_stream_fifo.sv
// First-word-fall-through stream buffer sitting below an sb7 node.
// Flow control and status come from registered state only; in_ready ignores out_ready.
module sb8_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  peak,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  peak_q, peak_d;
  logic              full_s, empty_s, push_s, pop_s;

  // Status flags and handshake qualification from registered occupancy.
  always_comb begin
    full_s  = (count_q == CNT_W'(DEPTH));
    empty_s = (count_q == CNT_W'(0));
    push_s  = in_valid && !full_s;
    pop_s   = out_ready && !empty_s;
  end

  // Next-state for pointers, occupancy and watermark.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    peak_d   = peak_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end
  end

  // Pointer, occupancy and watermark registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      peak_q   <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
    end
  end

  // Storage is deliberately left unreset; rst only blocks the write.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Output drive; the head word is masked to zero while empty.
  always_comb begin
    in_ready  = !full_s;
    out_valid = !empty_s;
    full      = full_s;
    empty     = empty_s;
    count     = count_q;
    peak      = peak_q;
    if (empty_s) begin
      out_data = DATA_W'(0);
    end else begin
      out_data = mem_q[rd_ptr_q];
    end
  end

endmodule
